// File: rtl/apb_cmd_master_if.sv
// Command, response and APB3 bus signals of the APB command master.
// The master modport is the initiator's view; slave is the host/fabric side.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 initiator: one command at a time becomes a SETUP/ACCESS transfer,
// with a programmable ACCESS-phase timeout and a valid/ready response.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel=1, penable=0, address phase
// ACCESS | psel=1, penable=1, waiting on pready or timeout
// RESP   | rsp_valid high until rsp_ready
module apb_cmd_master #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic             clock,
    input  logic             rst_n,
    apb_cmd_master_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_t                         state, state_nxt;
    logic [15:0]                    wait_cnt, wait_nxt;
    logic                           cmd_ready_q, cmd_ready_nxt;
    logic                           rsp_valid_q, rsp_valid_nxt;
    logic [DATA_BUS_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_nxt;
    logic                           rsp_err_q, rsp_err_nxt;
    logic                           psel_q, psel_nxt;
    logic                           penable_q, penable_nxt;
    logic                           pwrite_q, pwrite_nxt;
    logic [ADDRESS_BUS_WIDTH-1:0]   paddr_q, paddr_nxt;
    logic [DATA_BUS_WIDTH-1:0]      pwdata_q, pwdata_nxt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            cmd_ready_q <= cmd_ready_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_rdata_q <= rsp_rdata_nxt;
            rsp_err_q   <= rsp_err_nxt;
            psel_q      <= psel_nxt;
            penable_q   <= penable_nxt;
            pwrite_q    <= pwrite_nxt;
            paddr_q     <= paddr_nxt;
            pwdata_q    <= pwdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        rsp_rdata_nxt = rsp_rdata_q;
        rsp_err_nxt   = rsp_err_q;
        pwrite_nxt    = pwrite_q;
        paddr_nxt     = paddr_q;
        pwdata_nxt    = pwdata_q;

        case (state)
            S_IDLE: begin
                // cmd_ready_q gates acceptance so the cycle right after reset never accepts
                if (bus.cmd_valid && cmd_ready_q) begin
                    pwrite_nxt = bus.cmd_write;
                    paddr_nxt  = bus.cmd_addr;
                    pwdata_nxt = bus.cmd_write ? bus.cmd_wdata : '0;
                    wait_nxt   = '0;
                    state_nxt  = S_SETUP;
                end
            end
            S_SETUP: begin
                state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.pready) begin
                    rsp_rdata_nxt = pwrite_q ? '0 : bus.prdata;
                    rsp_err_nxt   = 1'b0;
                    state_nxt     = S_RESP;
                end else if (TO_EN && (wait_cnt == TO_LAST)) begin
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                    state_nxt     = S_RESP;
                end else begin
                    wait_nxt = wait_cnt + 16'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // registered outputs are decoded from the next state
        cmd_ready_nxt = (state_nxt == S_IDLE);
        psel_nxt      = (state_nxt == S_SETUP) || (state_nxt == S_ACCESS);
        penable_nxt   = (state_nxt == S_ACCESS);
        rsp_valid_nxt = (state_nxt == S_RESP);
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: vector table of single transfers,
// response scoreboard, and hand sequences for backpressure, reset and streaming.
module tb_apb_cmd_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    apb_cmd_master_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    apb_cmd_master #(
        .ADDRESS_BUS_WIDTH(16),
        .DATA_BUS_WIDTH   (32),
        .TIMEOUT_CYCLES   (4)
    ) dut (
        .clock(clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prd;
        logic [31:0] exp_pwdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb_q[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // response scoreboard: pop on each handshake
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    task automatic run_xfer(input vec_t v, input string tag);
        int cyc;
        int ws;
        bit done;
        wait_ready(tag);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        sb_q.push_back('{v.exp_rdata, v.exp_err});
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = 32'hFFFF_FFFF;
        chk({tag, "_setup_psel_pen"}, {30'd0, bus.psel, bus.penable}, 32'd2);
        chk({tag, "_setup_paddr"}, {16'd0, bus.paddr}, {16'd0, v.addr});
        chk({tag, "_setup_pwdata"}, bus.pwdata, v.exp_pwdata);
        chk({tag, "_setup_pwrite"}, {31'd0, bus.pwrite}, {31'd0, v.wr});
        chk({tag, "_setup_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
        tick();
        cyc  = 2;
        ws   = 0;
        done = 1'b0;
        while (!done && cyc < 60) begin
            chk({tag, "_access_psel_pen"}, {30'd0, bus.psel, bus.penable}, 32'd3);
            chk({tag, "_access_bus_stable"}, {bus.pwdata ^ {16'd0, bus.paddr}} ^ {31'd0, bus.pwrite},
                v.exp_pwdata ^ {16'd0, v.addr} ^ {31'd0, v.wr});
            if (ws == v.waits) begin
                bus.pready = 1'b1;
                bus.prdata = v.prd;
            end
            tick();
            bus.pready = 1'b0;
            bus.prdata = $urandom;
            cyc++;
            if (bus.rsp_valid) done = 1'b1;
            else ws++;
        end
        chk({tag, "_rsp_seen"}, {31'd0, done}, 32'd1);
        chk({tag, "_rsp_cycle"}, cyc, v.exp_cyc);
        chk({tag, "_rsp_psel_pen"}, {30'd0, bus.psel, bus.penable}, 32'd0);
        tick();
        chk({tag, "_idle_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        chk({tag, "_idle_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, {31'd0, bus.rsp_err}, 32'd0);
        chk({tag, "_psel_pen_pwrite"}, {29'd0, bus.psel, bus.penable, bus.pwrite}, 32'd0);
        chk({tag, "_paddr"}, {16'd0, bus.paddr}, 32'd0);
        chk({tag, "_pwdata"}, bus.pwdata, 32'd0);
    endtask

    initial begin
        logic [15:0] b2b_addr [3];
        int          acc [3];
        int          idx;
        int          last_acc;
        bit          fire;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        bus.prdata    = '0;
        bus.pready    = 1'b0;

        //           wr    addr      wdata         waits prdata        pwdata        rdata         err  cyc
        vecs[0] = '{1'b1, 16'h0003, 32'h00C08240, 0,  32'h0,        32'h00C08240, 32'h0,        1'b0, 3};
        vecs[1] = '{1'b0, 16'h0004, 32'h11111111, 2,  32'h00C4FFFF, 32'h0,        32'h00C4FFFF, 1'b0, 5};
        vecs[2] = '{1'b0, 16'h0010, 32'h0,        99, 32'hDEADBEEF, 32'h0,        32'h0,        1'b1, 6};
        vecs[3] = '{1'b0, 16'h0010, 32'h0,        3,  32'h12345678, 32'h0,        32'h12345678, 1'b0, 6};
        vecs[4] = '{1'b1, 16'h0022, 32'hCAFE0001, 1,  32'hDEADBEEF, 32'hCAFE0001, 32'h0,        1'b0, 4};
        vecs[5] = '{1'b1, 16'h8001, 32'h0F0F0F0F, 99, 32'h0,        32'h0F0F0F0F, 32'h0,        1'b1, 6};
        vecs[6] = '{1'b0, 16'hFFFE, 32'h0,        0,  32'h5A5A0001, 32'h0,        32'h5A5A0001, 1'b0, 3};

        #2;
        chk_all_zero("reset");
        tick();
        tick();
        chk("reset_held_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_cmd_ready_pre_edge", {31'd0, bus.cmd_ready}, 32'd0);
        tick();
        chk("release_cmd_ready_first_edge", {31'd0, bus.cmd_ready}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // reset in the second ACCESS cycle of a write
        wait_ready("rst");
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 16'h0040;
        bus.cmd_wdata = 32'h0000_0077;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        chk("rst_pre_access", {29'd0, bus.psel, bus.penable, bus.pwrite}, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_cmd_ready_pre", {31'd0, bus.cmd_ready}, 32'd0);
        tick();
        chk("rst_release_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("rst_no_rsp", {30'd0, bus.rsp_valid, bus.psel}, 32'd0);
            tick();
        end

        // backpressure with a second command held on cmd_valid
        bus.rsp_ready = 1'b0;
        wait_ready("bp");
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 16'h0030;
        sb_q.push_back('{32'hA5A5A5A5, 1'b0});
        tick();
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 16'h0031;
        bus.cmd_wdata = 32'h0BADCAFE;
        sb_q.push_back('{32'h0, 1'b0});
        tick();
        chk("bp_access_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        bus.pready = 1'b1;
        bus.prdata = 32'hA5A5A5A5;
        tick();
        bus.pready = 1'b0;
        bus.prdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_hold_rdata", bus.rsp_rdata, 32'hA5A5A5A5);
            chk("bp_hold_err_ready_psel", {29'd0, bus.rsp_err, bus.cmd_ready, bus.psel}, 32'd0);
            tick();
        end
        chk("bp_still_valid", {31'd0, bus.rsp_valid}, 32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_after_hs_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("bp_after_hs_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("bp_second_setup", {29'd0, bus.psel, bus.penable, bus.pwrite}, 32'd5);
        chk("bp_second_paddr", {16'd0, bus.paddr}, 32'h0031);
        chk("bp_second_pwdata", bus.pwdata, 32'h0BADCAFE);
        tick();
        bus.pready = 1'b1;
        tick();
        bus.pready = 1'b0;
        chk("bp_second_rsp", {31'd0, bus.rsp_valid}, 32'd1);
        tick();

        // back-to-back writes with everything tied high
        b2b_addr[0] = 16'h000B;
        b2b_addr[1] = 16'h000C;
        b2b_addr[2] = 16'h000D;
        bus.pready    = 1'b1;
        bus.prdata    = 32'hFFFF_FFFF;
        bus.rsp_ready = 1'b1;
        wait_ready("b2b");
        idx      = 0;
        last_acc = -100;
        fire     = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = b2b_addr[0];
        bus.cmd_wdata = {16'h1000, b2b_addr[0]};
        for (int c = 0; c < 60 && !(idx == 3 && (c - last_acc) > 4); c++) begin
            int d;
            d = c - last_acc;
            if (d == 1 || d == 2) begin
                chk("b2b_psel_high", {31'd0, bus.psel}, 32'd1);
                chk("b2b_paddr", {16'd0, bus.paddr}, {16'd0, b2b_addr[idx-1]});
            end else if (d == 3 || d == 4) begin
                chk("b2b_psel_gap", {31'd0, bus.psel}, 32'd0);
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc[idx] = c;
                sb_q.push_back('{32'h0, 1'b0});
                idx++;
                fire = 1'b1;
            end
            tick();
            if (fire) begin
                last_acc = c;
                fire     = 1'b0;
                if (idx < 3) begin
                    bus.cmd_addr  = b2b_addr[idx];
                    bus.cmd_wdata = {16'h1000, b2b_addr[idx]};
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
        end
        chk("b2b_accepted", idx, 3);
        if (idx == 3) begin
            chk("b2b_spacing_01", acc[1] - acc[0], 4);
            chk("b2b_spacing_12", acc[2] - acc[1], 4);
        end
        bus.pready = 1'b0;
        tick();
        tick();
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
